// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO.
// Holds the default data width, the address-width helper and the
// parameter legality predicates evaluated at elaboration by the top level.
package fifo_pkg;

  // Default word width used when the instantiating logic does not override it.
  localparam int DATA_W_DEF = 8;

  // Memory address width for a given depth.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Data width must be at least one bit.
  function automatic bit width_ok(input int width);
    return width >= 1;
  endfunction

  // Depth must be a power of two and hold at least two entries, so that the
  // pointer wrap bit cleanly distinguishes full from empty.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // almost_full threshold: 1..DEPTH.
  function automatic bit af_ok(input int depth, input int af_lvl);
    return (af_lvl >= 1) && (af_lvl <= depth);
  endfunction

  // almost_empty threshold: 0..DEPTH-1.
  function automatic bit ae_ok(input int depth, input int ae_lvl);
    return (ae_lvl >= 0) && (ae_lvl <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Purpose: DEPTH x DATA_W dual-port storage, synchronous write, asynchronous read.
// Latency: write lands at the wclk edge with we high; rdata follows raddr combinationally.
// Backpressure: none here; the caller only asserts we for accepted writes.
// Ports: wclk, we, waddr, wdata (write side); raddr, rdata (read side).
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16
) (
  input  logic                     wclk,
  input  logic                     we,
  input  logic [addr_w(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [addr_w(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  // Contents are deliberately not reset: nothing reads a slot before the
  // write pointer has passed it.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge wclk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Purpose: parametrised single-clock FIFO with occupancy count, almost flags, sticky errors.
// Latency: standard mode dout one cycle after an accepted read; FWFT mode head word shown
//          the cycle after it is written. Backpressure: writes refused when full unless a read
//          frees the slot in the same cycle; reads refused when empty; refusals set sticky flags.
// Ports: clk/rst_n (sync, active-low); wrt_sig/din write side; rd_sig/dout read side;
//        clr_err clears over_flow/under_flow; full/empty/almost flags and count report occupancy.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  parameter int FWFT   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wrt_sig,
  input  logic                       rd_sig,
  input  logic [DATA_W-1:0]          din,
  input  logic                       clr_err,
  output logic [DATA_W-1:0]          dout,
  output logic                       full_sig,
  output logic                       empty_sig,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [addr_w(DEPTH):0]     count,
  output logic                       over_flow,
  output logic                       under_flow
);

  localparam int AW = addr_w(DEPTH);
  // Pointers and count share the same width: AW address bits plus one more
  // (wrap bit for pointers, room for the value DEPTH in the count).
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (!width_ok(DATA_W)) begin : g_bad_width
    $error("param_sync_fifo: DATA_W must be at least 1");
  end
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two and at least 2");
  end
  if (!af_ok(DEPTH, AF_LVL)) begin : g_bad_af
    $error("param_sync_fifo: AF_LVL must lie in 1..DEPTH");
  end
  if (!ae_ok(DEPTH, AE_LVL)) begin : g_bad_ae
    $error("param_sync_fifo: AE_LVL must lie in 0..DEPTH-1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              over_flow_q, over_flow_d;
  logic              under_flow_q, under_flow_d;

  logic              rd_ok;
  logic              wr_ok;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Flags decode straight from the count register so they change only at
  // clock edges and never glitch across a pointer wrap.
  assign full_sig     = (count_q == DEPTH_C);
  assign empty_sig    = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign over_flow    = over_flow_q;
  assign under_flow   = under_flow_q;

  // A read is judged first; a write into a full FIFO is still taken when the
  // same-cycle read frees a slot. No bypass on empty: the read is refused.
  assign rd_ok = rd_sig && !empty_sig;
  assign wr_ok = wrt_sig && (!full_sig || rd_ok);

  // Requests presented during a reset cycle must not disturb memory.
  assign mem_we = wr_ok && rst_n;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    over_flow_d  = over_flow_q;
    under_flow_d = under_flow_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ONE_C;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + ONE_C;
    end

    if (wr_ok && !rd_ok) begin
      count_d = count_q + ONE_C;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - ONE_C;
    end

    // A new error in the clear cycle takes priority so it is never lost.
    if (wrt_sig && !wr_ok) begin
      over_flow_d = 1'b1;
    end else if (clr_err) begin
      over_flow_d = 1'b0;
    end

    if (rd_sig && !rd_ok) begin
      under_flow_d = 1'b1;
    end else if (clr_err) begin
      under_flow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      over_flow_q  <= 1'b0;
      under_flow_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      over_flow_q  <= over_flow_d;
      under_flow_q <= under_flow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .wclk  (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  if (FWFT == 0) begin : g_std
    // Registered read: dout only moves on an accepted read and holds through
    // refused reads, so a consumer can sample it at leisure.
    logic [DATA_W-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_ok) begin
        dout_d = mem_rdata;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign dout = dout_q;
  end else begin : g_fwft
    // Head of queue is presented directly; forced to zero while empty so a
    // stale slot is never visible.
    assign dout = empty_sig ? '0 : mem_rdata;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Purpose: self-checking bench for param_sync_fifo, standard and FWFT instances side by side.
// Latency: inputs driven #1 after a rising edge, outputs sampled #1 after the next one.
// Backpressure: expected accept/refuse decisions come from a queue-based reference model.
module tb_param_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wrt_sig = 1'b0;
  logic          rd_sig = 1'b0;
  logic [DW-1:0] din = '0;
  logic          clr_err = 1'b0;

  logic [DW-1:0] dout_s, dout_f;
  logic          full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [4:0]    count_s, count_f;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue plus the sticky flags and the held read word.
  logic [DW-1:0] mq [$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  logic [DW-1:0] m_dout = '0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_LVL(AF), .AE_LVL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wrt_sig(wrt_sig), .rd_sig(rd_sig), .din(din), .clr_err(clr_err),
    .dout(dout_s), .full_sig(full_s), .empty_sig(empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .count(count_s), .over_flow(ovf_s), .under_flow(unf_s)
  );

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_LVL(AF), .AE_LVL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wrt_sig(wrt_sig), .rd_sig(rd_sig), .din(din), .clr_err(clr_err),
    .dout(dout_f), .full_sig(full_f), .empty_sig(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(count_f), .over_flow(ovf_f), .under_flow(unf_f)
  );

  // Apply one cycle's worth of requests, let the edge happen, then advance the model
  // using the same requests that the DUT saw.
  task automatic model_step();
    bit can_rd, can_wr;
    if (!rst_n) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dout = '0;
      return;
    end
    can_rd = rd_sig && (mq.size() > 0);
    can_wr = wrt_sig && ((mq.size() < DP) || can_rd);
    if (can_rd) begin
      m_dout = mq.pop_front();
    end
    if (can_wr) begin
      mq.push_back(din);
    end
    if (wrt_sig && !can_wr) m_ovf = 1'b1;
    else if (clr_err)       m_ovf = 1'b0;
    if (rd_sig && !can_rd)  m_unf = 1'b1;
    else if (clr_err)       m_unf = 1'b0;
  endtask

  task automatic drive(input bit rs, input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    rst_n = rs; wrt_sig = w; rd_sig = r; clr_err = c; din = d;
    @(posedge clk);
    #1;
    model_step();
    rst_n = 1'b1; wrt_sig = 1'b0; rd_sig = 1'b0; clr_err = 1'b0;
  endtask

  function automatic logic [DW-1:0] m_head();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h33);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (count_s !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_s); end
    checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty_s); end
    checks++; if (ae_s !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %b want 1", ae_s); end
    checks++; if (full_s !== 1'b0 || af_s !== 1'b0) begin errors++; $display("FAIL reset_full got full=%b af=%b want 0 0", full_s, af_s); end
    checks++; if (dout_s !== 8'h00 || dout_f !== 8'h00) begin errors++; $display("FAIL reset_dout got %h/%h want 00/00", dout_s, dout_f); end
    checks++; if (ovf_s !== 1'b0 || unf_s !== 1'b0) begin errors++; $display("FAIL reset_err got ovf=%b unf=%b want 0 0", ovf_s, unf_s); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DP + 1; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
      checks++; if (count_s !== 5'(mq.size())) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count_s, mq.size()); end
      checks++; if (af_s !== (mq.size() >= AF)) begin errors++; $display("FAIL fill_af[%0d] got %b want %b", i, af_s, mq.size() >= AF); end
      checks++; if (full_s !== (mq.size() == DP)) begin errors++; $display("FAIL fill_full[%0d] got %b want %b", i, full_s, mq.size() == DP); end
      checks++; if (ovf_s !== m_ovf) begin errors++; $display("FAIL fill_ovf[%0d] got %b want %b", i, ovf_s, m_ovf); end
      checks++; if (dout_f !== 8'h00) begin errors++; $display("FAIL fill_fwft_head[%0d] got %h want 00", i, dout_f); end
    end
    checks++; if (count_s !== 5'd16 || ovf_s !== 1'b1) begin errors++; $display("FAIL fill_end got count=%0d ovf=%b want 16 1", count_s, ovf_s); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DP + 1; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (dout_s !== 8'((i < DP) ? i : DP - 1)) begin errors++; $display("FAIL drain_dout[%0d] got %h want %h", i, dout_s, 8'((i < DP) ? i : DP - 1)); end
      checks++; if (dout_f !== m_head()) begin errors++; $display("FAIL drain_fwft[%0d] got %h want %h", i, dout_f, m_head()); end
      checks++; if (empty_s !== (i >= DP - 1)) begin errors++; $display("FAIL drain_empty[%0d] got %b want %b", i, empty_s, i >= DP - 1); end
      checks++; if (unf_s !== (i == DP)) begin errors++; $display("FAIL drain_unf[%0d] got %b want %b", i, unf_s, i == DP); end
    end
  endtask

  task automatic test_full_rw();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DP; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hAA);
    checks++; if (count_s !== 5'd16) begin errors++; $display("FAIL fullrw_count got %0d want 16", count_s); end
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL fullrw_ovf got %b want 0", ovf_s); end
    for (int i = 0; i < DP; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (dout_s !== m_dout) begin errors++; $display("FAIL fullrw_dout[%0d] got %h want %h", i, dout_s, m_dout); end
    end
    checks++; if (dout_s !== 8'hAA || empty_s !== 1'b1) begin errors++; $display("FAIL fullrw_last got %h empty=%b want aa 1", dout_s, empty_s); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);  // read on empty -> under_flow
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom_range(0, 255));
      drive(1'b1, 1'b1, 1'b1, 1'b0, v);
      checks++; if (count_s !== 5'd5 || af_s !== 1'b0 || ae_s !== 1'b0 || full_s !== 1'b0 || empty_s !== 1'b0) begin
        errors++; $display("FAIL b2b_flags[%0d] got count=%0d af=%b ae=%b full=%b empty=%b want 5 0 0 0 0", i, count_s, af_s, ae_s, full_s, empty_s);
      end
      checks++; if (dout_s !== m_dout || dout_f !== m_head()) begin errors++; $display("FAIL b2b_data[%0d] got %h/%h want %h/%h", i, dout_s, dout_f, m_dout, m_head()); end
    end
    checks++; if (unf_s !== 1'b1) begin errors++; $display("FAIL b2b_unf_sticky got %b want 1", unf_s); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (unf_s !== 1'b0 || ovf_s !== 1'b0) begin errors++; $display("FAIL clr_err got ovf=%b unf=%b want 0 0", ovf_s, unf_s); end
    // Drain, then a refused read in the same cycle as clr_err must still set the flag.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    checks++; if (unf_s !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %b want 1", unf_s); end
    // Empty with both requests: write taken, read refused, word visible next cycle.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
    checks++; if (count_s !== 5'd1 || unf_s !== 1'b1 || dout_f !== 8'h77) begin
      errors++; $display("FAIL empty_both got count=%0d unf=%b fwft=%h want 1 1 77", count_s, unf_s, dout_f);
    end
  endtask

  task automatic test_fwft();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
    checks++; if (dout_f !== 8'h5A || dout_s !== 8'h00) begin errors++; $display("FAIL fwft_show got %h std=%h want 5a 00", dout_f, dout_s); end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (dout_f !== 8'h00 || empty_f !== 1'b1 || dout_s !== 8'h5A) begin
      errors++; $display("FAIL fwft_pop got %h empty=%b std=%h want 00 1 5a", dout_f, empty_f, dout_s);
    end
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(i + 1));
    checks++; if (count_f !== 5'd9) begin errors++; $display("FAIL fwft_fill got %0d want 9", count_f); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hEE);
    checks++; if (count_f !== 5'd0 || count_s !== 5'd0 || empty_f !== 1'b1) begin
      errors++; $display("FAIL midstream_reset got %0d/%0d empty=%b want 0/0 1", count_f, count_s, empty_f);
    end
  endtask

  task automatic test_random();
    bit w, r, c, rs;
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 149) != 0);
      w  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 65 : 35));
      r  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 65));
      c  = ($urandom_range(0, 19) == 0);
      drive(rs, w, r, c, 8'($urandom_range(0, 255)));
      checks++; if (count_s !== 5'(mq.size()) || count_f !== 5'(mq.size())) begin
        errors++; $display("FAIL rnd_count[%0d] got %0d/%0d want %0d", i, count_s, count_f, mq.size());
      end
      checks++; if (full_s !== (mq.size() == DP) || empty_s !== (mq.size() == 0) || full_f !== full_s || empty_f !== empty_s) begin
        errors++; $display("FAIL rnd_fullempty[%0d] got %b%b/%b%b want %b%b", i, full_s, empty_s, full_f, empty_f, mq.size() == DP, mq.size() == 0);
      end
      checks++; if (af_s !== (mq.size() >= AF) || ae_s !== (mq.size() <= AE) || af_f !== af_s || ae_f !== ae_s) begin
        errors++; $display("FAIL rnd_almost[%0d] got af=%b ae=%b want %b %b", i, af_s, ae_s, mq.size() >= AF, mq.size() <= AE);
      end
      checks++; if (ovf_s !== m_ovf || unf_s !== m_unf || ovf_f !== m_ovf || unf_f !== m_unf) begin
        errors++; $display("FAIL rnd_err[%0d] got %b%b/%b%b want %b%b", i, ovf_s, unf_s, ovf_f, unf_f, m_ovf, m_unf);
      end
      checks++; if (dout_s !== m_dout || dout_f !== m_head()) begin
        errors++; $display("FAIL rnd_dout[%0d] got %h/%h want %h/%h", i, dout_s, dout_f, m_dout, m_head());
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_back_to_back();
    test_fwft();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
